// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory access unit: access size codes,
// FSM state type and byte-enable constants.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    // Half accesses look only at lane[1], so a set addr[0] is simply ignored.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = BE_BYTE0 << lane;
            SIZE_HALF: be = lane[1] ? BE_HALF_HI : BE_HALF_LO;
            default:   be = BE_WORD;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the addressed byte/half out of the read
// word and sign- or zero-extends it to B bits. Assumes B >= 32.
module load_align
    import mips_mem_pkg::*;
#(
    parameter int B = 32
) (
    input  logic [B-1:0] rdata,
    input  logic [1:0]   size,
    input  logic         zero_ext,
    input  logic [1:0]   lane,
    output logic [B-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (lane)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (size)
            SIZE_BYTE: data = zero_ext ? {{(B-8){1'b0}}, byte_v}
                                       : {{(B-8){byte_v[7]}}, byte_v};
            SIZE_HALF: data = zero_ext ? {{(B-16){1'b0}}, half_v}
                                       : {{(B-16){half_v[15]}}, half_v};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues loads/stores, stalls the pipeline
// until ack, aligns load data. Optional misalignment trap: MEM_MISALIGN_TRAP_EN.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int B = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mem_MemRead_in,
    input  logic         mem_MemWrite_in,
    input  logic [1:0]   mem_size_in,
    input  logic         mem_unsigned_in,
    input  logic [B-1:0] alu_result_in,
    input  logic [B-1:0] write_data_in,
    output logic [B-1:0] read_data_out,
    output logic         stall_out,
    output logic         dmem_req_out,
    output logic         dmem_we_out,
    output logic [B-1:0] dmem_addr_out,
    output logic [B-1:0] dmem_wdata_out,
    output logic [3:0]   dmem_be_out,
    input  logic         dmem_ack_in,
    input  logic [B-1:0] dmem_rdata_in,
    output logic         misalign_out,
    output mem_state_t   state_dbg
);

    // dmem handshake: req is the valid; once raised, addr/we/be/wdata hold
    // steady until ack (the ready) is seen at a rising edge, which completes
    // the transfer and drops req on that same edge. ack is ignored otherwise.

    mem_state_t   state, state_next;
    logic [1:0]   size_eff;
    logic         req_any;
    logic         aligned;
    logic         access_ok;
    logic         post_reset_hold;
    logic [B-1:0] wdata_rep;
    logic [B-1:0] load_data;

    logic         req_q, we_q, load_q, unsigned_q;
    logic [B-1:0] addr_q, wdata_q, rdata_q;
    logic [3:0]   be_q;
    logic [1:0]   size_q, lane_q;

    assign req_any  = mem_MemRead_in | mem_MemWrite_in;
    assign size_eff = (mem_size_in == SIZE_RSVD) ? SIZE_WORD : mem_size_in;

`ifdef MEM_MISALIGN_TRAP_EN
    assign aligned = !(((size_eff == SIZE_HALF) && alu_result_in[0]) ||
                       ((size_eff == SIZE_WORD) && (alu_result_in[1:0] != 2'b00)));
`else
    assign aligned = 1'b1;
`endif

    // After reset the request that was in flight stays blocked until the inputs go idle.
    assign access_ok = req_any && aligned && !post_reset_hold;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (access_ok)   state_next = ST_BUSY;
            ST_BUSY: if (dmem_ack_in) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_out = (state == ST_BUSY) || ((state == ST_IDLE) && access_ok);
        state_dbg = state;
    end

    always_comb begin
        wdata_rep = write_data_in;
        case (size_eff)
            SIZE_BYTE: wdata_rep[31:0] = {4{write_data_in[7:0]}};
            SIZE_HALF: wdata_rep[31:0] = {2{write_data_in[15:0]}};
            default:   wdata_rep[31:0] = write_data_in[31:0];
        endcase
    end

    load_align #(.B(B)) u_load_align (
        .rdata    (dmem_rdata_in),
        .size     (size_q),
        .zero_ext (unsigned_q),
        .lane     (lane_q),
        .data     (load_data)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            load_q          <= 1'b0;
            unsigned_q      <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rdata_q         <= '0;
            be_q            <= BE_NONE;
            size_q          <= SIZE_BYTE;
            lane_q          <= 2'b00;
            post_reset_hold <= 1'b1;
        end else begin
            if (!req_any) post_reset_hold <= 1'b0;
            if ((state == ST_IDLE) && access_ok) begin
                req_q      <= 1'b1;
                we_q       <= mem_MemWrite_in;
                load_q     <= mem_MemRead_in && !mem_MemWrite_in;
                unsigned_q <= mem_unsigned_in;
                addr_q     <= {alu_result_in[B-1:2], 2'b00};
                wdata_q    <= wdata_rep;
                be_q       <= byte_enable(size_eff, alu_result_in[1:0]);
                size_q     <= size_eff;
                lane_q     <= alu_result_in[1:0];
            end else if ((state == ST_BUSY) && dmem_ack_in) begin
                req_q <= 1'b0;
                we_q  <= 1'b0;
                if (load_q) rdata_q <= load_data;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;
    always_ff @(posedge clk) begin
        if (!reset_n) misalign_q <= 1'b0;
        else          misalign_q <= (state == ST_IDLE) && req_any && !aligned && !post_reset_hold;
    end
    assign misalign_out = misalign_q;
`else
    assign misalign_out = 1'b0;
`endif

    assign read_data_out  = rdata_q;
    assign dmem_req_out   = req_q;
    assign dmem_we_out    = we_q;
    assign dmem_addr_out  = addr_q;
    assign dmem_wdata_out = wdata_q;
    assign dmem_be_out    = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit; covers both builds of MEM_MISALIGN_TRAP_EN.
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    localparam int B  = 32;
    localparam int RW = 1 + B + 4 + B;

    logic         clk;
    logic         reset_n;
    logic         mem_MemRead_in, mem_MemWrite_in, mem_unsigned_in;
    logic [1:0]   mem_size_in;
    logic [B-1:0] alu_result_in, write_data_in;
    logic [B-1:0] read_data_out;
    logic         stall_out, dmem_req_out, dmem_we_out;
    logic [B-1:0] dmem_addr_out, dmem_wdata_out;
    logic [3:0]   dmem_be_out;
    logic         dmem_ack_in;
    logic [B-1:0] dmem_rdata_in;
    logic         misalign_out;
    mem_state_t   state_dbg;

    logic [RW-1:0] exp_q[$];
    logic [B-1:0]  exp_rd_q[$];
    logic [B-1:0]  last_load;
    int            n_checks;
    int            n_pass;

    mem_access_unit #(.B(B)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_MemRead_in  (mem_MemRead_in),
        .mem_MemWrite_in (mem_MemWrite_in),
        .mem_size_in     (mem_size_in),
        .mem_unsigned_in (mem_unsigned_in),
        .alu_result_in   (alu_result_in),
        .write_data_in   (write_data_in),
        .read_data_out   (read_data_out),
        .stall_out       (stall_out),
        .dmem_req_out    (dmem_req_out),
        .dmem_we_out     (dmem_we_out),
        .dmem_addr_out   (dmem_addr_out),
        .dmem_wdata_out  (dmem_wdata_out),
        .dmem_be_out     (dmem_be_out),
        .dmem_ack_in     (dmem_ack_in),
        .dmem_rdata_in   (dmem_rdata_in),
        .misalign_out    (misalign_out),
        .state_dbg       (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // reference model
    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            SIZE_BYTE: return 4'b0001 << lane;
            SIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] exp_wrep(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            SIZE_BYTE: return {4{wd[7:0]}};
            SIZE_HALF: return {2{wd[15:0]}};
            default:   return wd;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] lane);
        logic [31:0] sh;
        case (sz)
            SIZE_BYTE: begin
                sh = w >> {lane, 3'b000};
                return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            SIZE_HALF: begin
                sh = w >> {lane[1], 4'b0000};
                return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: return w;
        endcase
    endfunction

    // driver tasks
    task automatic clear_inputs();
        mem_MemRead_in  = 1'b0;
        mem_MemWrite_in = 1'b0;
        mem_size_in     = SIZE_WORD;
        mem_unsigned_in = 1'b0;
        alu_result_in   = '0;
        write_data_in   = '0;
    endtask

    // Entered and left just after a rising edge with the FSM in IDLE.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int wait_n, input string tag);
        int          stall_cnt;
        logic        is_load;
        logic [31:0] want_rd;
        is_load = rd && !wr;
        exp_q.push_back({wr, addr & 32'hFFFF_FFFC, exp_be(sz, addr[1:0]), exp_wrep(sz, wd)});
        if (is_load) exp_rd_q.push_back(exp_load(rdata, sz, uns, addr[1:0]));
        mem_MemRead_in  = rd;
        mem_MemWrite_in = wr;
        mem_size_in     = sz;
        mem_unsigned_in = uns;
        alu_result_in   = addr;
        write_data_in   = wd;
        stall_cnt = 0;

        @(negedge clk);
        if (stall_out) stall_cnt++;
        n_checks++;
        if ({dmem_req_out, state_dbg} !== {1'b0, ST_IDLE})
            $display("FAIL %s issue_cycle: req/state got %b/%0d want 0/IDLE", tag, dmem_req_out, state_dbg);
        else n_pass++;
        @(posedge clk); #1;

        for (int i = 0; i <= wait_n; i++) begin
            if (i == wait_n) begin
                dmem_ack_in   = 1'b1;
                dmem_rdata_in = rdata;
            end
            @(negedge clk);
            if (stall_out) stall_cnt++;
            n_checks++;
            if (exp_q.size() == 0)
                $display("FAIL %s busy_req: scoreboard empty", tag);
            else if ({dmem_req_out, dmem_we_out, dmem_addr_out, dmem_be_out, dmem_wdata_out} !== {1'b1, exp_q[0]})
                $display("FAIL %s busy_req: got req=%b we=%b addr=%h be=%b wdata=%h want req=1 %h",
                         tag, dmem_req_out, dmem_we_out, dmem_addr_out, dmem_be_out, dmem_wdata_out, exp_q[0]);
            else n_pass++;
            if (i != wait_n) begin
                @(posedge clk); #1;
            end
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(posedge clk); #1;
        dmem_ack_in   = 1'b0;
        dmem_rdata_in = $urandom;

        @(negedge clk);
        if (stall_out) stall_cnt++;
        n_checks++;
        if ({stall_out, dmem_req_out, state_dbg} !== {1'b0, 1'b0, ST_DONE})
            $display("FAIL %s done_cycle: stall/req/state got %b/%b/%0d want 0/0/DONE",
                     tag, stall_out, dmem_req_out, state_dbg);
        else n_pass++;
        if (is_load) begin
            want_rd   = exp_rd_q.pop_front();
            last_load = want_rd;
        end else begin
            want_rd = last_load;
        end
        n_checks++;
        if (read_data_out !== want_rd)
            $display("FAIL %s read_data: got %h want %h", tag, read_data_out, want_rd);
        else n_pass++;
        n_checks++;
        if (stall_cnt != 2 + wait_n)
            $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cnt, 2 + wait_n);
        else n_pass++;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    // scenarios
    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        dmem_ack_in   = 1'b0;
        dmem_rdata_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({read_data_out, dmem_addr_out, dmem_wdata_out, dmem_be_out, dmem_req_out,
             dmem_we_out, stall_out, misalign_out, state_dbg} !== {{(3*B){1'b0}}, 4'b0000, 4'b0000, ST_IDLE})
            $display("FAIL reset_state: rd=%h addr=%h wd=%h be=%b req=%b we=%b stall=%b mis=%b st=%0d want all 0/IDLE",
                     read_data_out, dmem_addr_out, dmem_wdata_out, dmem_be_out, dmem_req_out,
                     dmem_we_out, stall_out, misalign_out, state_dbg);
        else n_pass++;
        last_load = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_no_access();
        dmem_ack_in   = 1'b1;
        dmem_rdata_in = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if ({stall_out, dmem_req_out, state_dbg} !== {1'b0, 1'b0, ST_IDLE})
            $display("FAIL idle_ack: stall/req/state got %b/%b/%0d want 0/0/IDLE", stall_out, dmem_req_out, state_dbg);
        else n_pass++;
        @(posedge clk); #1;
        dmem_ack_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({state_dbg, read_data_out} !== {ST_IDLE, last_load})
            $display("FAIL idle_ack_hold: state/rd got %0d/%h want IDLE/%h", state_dbg, read_data_out, last_load);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_lw_wait();
        do_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 2, "lw_0x100_w2");
    endtask

    task automatic test_lb_ext();
        do_access(1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0, "lb_signed");
        do_access(1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1, "lbu");
        do_access(1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h0000_0102, 32'h0, 32'h9234_5678, 0, "lh_hi_signed");
    endtask

    task automatic test_sh_store();
        do_access(1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1, "sh_0x202");
        do_access(1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h0000_0301, 32'h0000_00A5, 32'h0, 0, "sb_0x301");
    endtask

    task automatic test_read_write_both();
        do_access(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h0000_0400, 32'h5555_AAAA, 32'h1111_2222, 1, "rw_both_store");
    endtask

    task automatic test_size_reserved();
        do_access(1'b1, 1'b0, SIZE_RSVD, 1'b1, 32'h0000_0300, 32'h0, 32'h8765_4321, 0, "size11_word");
    endtask

    task automatic test_reset_busy();
        mem_MemRead_in = 1'b1;
        mem_size_in    = SIZE_WORD;
        alu_result_in  = 32'h0000_0500;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({dmem_req_out, state_dbg} !== {1'b1, ST_BUSY})
            $display("FAIL rst_busy_pre: req/state got %b/%0d want 1/BUSY", dmem_req_out, state_dbg);
        else n_pass++;
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({dmem_req_out, stall_out, state_dbg} !== {1'b0, 1'b0, ST_IDLE})
            $display("FAIL rst_busy_abort: req/stall/state got %b/%b/%0d want 0/0/IDLE",
                     dmem_req_out, stall_out, state_dbg);
        else n_pass++;
        last_load = '0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({dmem_req_out, stall_out, state_dbg} !== {1'b0, 1'b0, ST_IDLE})
            $display("FAIL rst_no_reissue: req/stall/state got %b/%b/%0d want 0/0/IDLE",
                     dmem_req_out, stall_out, state_dbg);
        else n_pass++;
        clear_inputs();
        @(posedge clk); #1;
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        mem_MemRead_in = 1'b1;
        mem_size_in    = SIZE_WORD;
        alu_result_in  = 32'h0000_0101;
        @(negedge clk);
        n_checks++;
        if ({stall_out, dmem_req_out} !== 2'b00)
            $display("FAIL misalign_nostall: stall/req got %b/%b want 0/0", stall_out, dmem_req_out);
        else n_pass++;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if ({misalign_out, dmem_req_out, state_dbg} !== {1'b1, 1'b0, ST_IDLE})
            $display("FAIL misalign_pulse: mis/req/state got %b/%b/%0d want 1/0/IDLE",
                     misalign_out, dmem_req_out, state_dbg);
        else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({misalign_out, read_data_out} !== {1'b0, last_load})
            $display("FAIL misalign_once: mis/rd got %b/%h want 0/%h", misalign_out, read_data_out, last_load);
        else n_pass++;
        @(posedge clk); #1;
    endtask
`else
    task automatic test_misalign();
        do_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h0000_0101, 32'h0, 32'h0BAD_C0DE, 0, "lw_0x101_ignored");
        do_access(1'b1, 1'b0, SIZE_HALF, 1'b1, 32'h0000_0103, 32'h0, 32'hBEEF_1234, 0, "lhu_0x103_ignored");
        @(negedge clk);
        n_checks++;
        if (misalign_out !== 1'b0)
            $display("FAIL misalign_tied: got %b want 0", misalign_out);
        else n_pass++;
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_back_to_back();
        logic [1:0]  sz;
        logic [31:0] addr;
        int          mode;
        for (int n = 0; n < 24; n++) begin
            sz   = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 2);
            addr = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
            if (sz == SIZE_HALF) addr[0] = 1'b0;
            if (sz == SIZE_WORD || sz == SIZE_RSVD) addr[1:0] = 2'b00;
`endif
            do_access(mode != 1, mode != 0, sz, 1'($urandom_range(0, 1)), addr, $urandom, $urandom,
                      $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_idle_no_access();
        test_lw_wait();
        test_lb_ext();
        test_sh_store();
        test_read_write_both();
        test_size_reserved();
        test_misalign();
        test_reset_busy();
        test_back_to_back();
        test_idle_no_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter B, default 32, SHALL set the data/address width; byte lanes are fixed at 4.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset_n  in  1  reset, synchronous and active-low.
REQ-004 mem_MemRead_in  in  1  load request from the EX/MEM latch.
REQ-005 mem_MemWrite_in  in  1  store request from the EX/MEM latch.
REQ-006 mem_size_in  in  2  access size: 00 byte, 01 half, 10 word; 11 SHALL be treated as word.
REQ-007 mem_unsigned_in  in  1  load extension: 1 zero-extend, 0 sign-extend.
REQ-008 alu_result_in  in  B  effective byte address.
REQ-009 write_data_in  in  B  store data, right-justified.
REQ-010 read_data_out  out  B  aligned and extended load data, routed to the MEM/WB latch.
REQ-011 stall_out  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-012 dmem_req_out, dmem_we_out  out  1 each  data-memory request and write enable.
REQ-013 dmem_addr_out  out  B  word-aligned address (bits [1:0] = 00).
REQ-014 dmem_wdata_out  out  B  lane-replicated store data.
REQ-015 dmem_be_out  out  4  byte enables.
REQ-016 dmem_ack_in  in  1  memory completion; dmem_rdata_in  in  B  read word, valid with ack.
REQ-017 misalign_out  out  1  misaligned-access pulse.

Function
REQ-018 FSM states SHALL be IDLE, BUSY and DONE.
REQ-019 IDLE: when MemRead or MemWrite is high (and, with the macro, the access is aligned), stall_out SHALL be high combinationally, all dmem_* outputs SHALL be registered, and the FSM SHALL move to BUSY.
REQ-020 BUSY: dmem_req_out and stall_out SHALL be high, and dmem_addr/we/be/wdata SHALL hold steady until dmem_ack_in is high; on ack the FSM SHALL move to DONE and req SHALL drop at that edge.
REQ-021 A load SHALL register read_data_out on the ack edge; read_data_out SHALL hold until the next load completes.
REQ-022 DONE: stall_out SHALL be low for exactly 1 cycle so the latches advance; the FSM SHALL then return to IDLE. DONE SHALL never start a new access.
REQ-023 Latency: an access seen in cycle T with ack in cycle T+1+W SHALL stall for 2+W cycles, with data valid from cycle T+2+W.
REQ-024 When MemRead and MemWrite are both high, the access SHALL be a store and the read SHALL be ignored.
REQ-025 dmem_ack_in SHALL be ignored in IDLE and DONE.
REQ-026 Store byte enables: byte = 0001 shifted left by addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
REQ-027 Store data: byte replicated 4x; half replicated 2x.
REQ-028 Load: the lane selected by addr SHALL be extracted and extended to B per mem_unsigned_in; word loads SHALL pass through unchanged.
REQ-029 With no access requested, stall_out SHALL be 0 and the FSM SHALL stay in IDLE.

Reset
REQ-030 On reset_n low at a clock edge: FSM = IDLE; read_data_out, dmem_addr_out, dmem_wdata_out = 0; dmem_be_out = 0000; req, we, stall_out, misalign_out = 0.
REQ-031 Reset in BUSY SHALL abort the access; the unit SHALL not re-issue it after reset.

Configuration
REQ-032 Macro MEM_MISALIGN_TRAP_EN. When defined, a half access with addr[0]=1 or a word access with addr[1:0]≠00 SHALL issue no request and no stall, SHALL pulse misalign_out for 1 cycle, and SHALL leave read_data_out unchanged.
REQ-033 When MEM_MISALIGN_TRAP_EN is undefined, misalign_out SHALL be tied to 0; half accesses SHALL ignore addr[0] and word accesses SHALL ignore addr[1:0].

Structure
REQ-034 Shared package mips_mem_pkg SHALL hold the size encodings, the FSM state type, and the byte-enable constants.
REQ-035 Load lane extraction and extension SHALL be a combinational sub-module, load_align.

Verification
REQ-036 LW addr 0x100, ack after 2 wait cycles -> stall high for 4 cycles, be=1111, read_data_out = rdata.
REQ-037 LB signed addr 0x103, rdata 0x80FFFFFF -> read_data_out 0xFFFFFF80; with LBU -> 0x00000080.
REQ-038 SH addr 0x202, data 0x1234ABCD -> be=1100, wdata 0xABCDABCD, we=1.
REQ-039 MemRead=MemWrite=1 -> store issued, we=1, read_data_out unchanged.
REQ-040 reset_n low during BUSY -> next edge: req=0, stall=0, FSM=IDLE.
REQ-041 Macro on, LW addr 0x101 -> misalign_out pulses once, no req; macro off -> addr 0x100, be=1111.
